// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel combinator and its queue fabric.
package pixel_pkg;

    // Colour width used by the result queues.
    localparam int COLOUR_W = 24;

    // Coordinate broadcast when no pixel is being requested. It differs from
    // the all-ones empty-queue marker and from any on-screen coordinate.
    localparam logic [31:0] IDLE_COORD = 32'hFFFF_FFFE;

    // Upper byte of each output word above the colour.
    localparam logic [7:0] TDATA_PAD = 8'h00;

    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_combinator_if.sv
// Queue-side coordinate broadcast and output pixel stream of the combinator.
interface pixel_combinator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RBG_SIZE   = 24,
    parameter int NUM_QUEUES = 4
);
    // Coordinate request to the queues and their answers
    logic [DATA_WIDTH-1:0]          xpixel_check;
    logic [DATA_WIDTH-1:0]          ypixel_check;
    logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i;
    logic [NUM_QUEUES-1:0]          hit_i;

    // Outgoing pixel stream
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tuser;
    logic        out_tlast;

    modport master (
        output xpixel_check, ypixel_check,
        input  colour_i, hit_i,
        output out_tdata, out_tvalid, out_tuser, out_tlast,
        input  out_tready
    );

    modport slave (
        input  xpixel_check, ypixel_check,
        output colour_i, hit_i,
        input  out_tdata, out_tvalid, out_tuser, out_tlast,
        output out_tready
    );

endinterface

// File: rtl/pixel_combinator_raster_counter.sv
// Raster-order x/y position with end-of-line / end-of-frame flags.
module raster_counter #(
    parameter int DATA_WIDTH    = 32,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] x_next,
    output logic [DATA_WIDTH-1:0] y_next,
    output logic                  eol,
    output logic                  eof
);

    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    assign eol = (x == X_LAST);
    assign eof = eol && (y == Y_LAST);

    // Position following the current one, wrapping at line and frame end.
    always_comb begin
        x_next = x + 1'b1;
        y_next = y;
        if (eol) begin
            x_next = '0;
            y_next = eof ? '0 : y + 1'b1;
        end
    end

    // Position register: cleared at frame start, stepped once per accepted pixel.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= x_next;
            y <= y_next;
        end
    end

endmodule

// File: rtl/pixel_combinator.sv
// Raster-order drain of the per-engine result queues: requests each pixel by
// coordinate, takes the colour from whichever queue answers, and streams it
// out in order with start-of-frame and end-of-line markers.
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int RBG_SIZE      = COLOUR_W,
    parameter int NUM_QUEUES    = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int TIMEOUT       = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    pixel_combinator_if.master bus,
    output logic               busy,
    output logic               timeout_err
);

    localparam int                    TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] COORD_IDLE = DATA_WIDTH'(IDLE_COORD);

    state_t                state, state_n;
    logic [TIMER_W-1:0]    timer, timer_n;
    logic [DATA_WIDTH-1:0] xcheck, xcheck_n;
    logic [DATA_WIDTH-1:0] ycheck, ycheck_n;
    logic [31:0]           tdata, tdata_n;
    logic                  tvalid, tvalid_n;
    logic                  tuser, tuser_n;
    logic                  tlast, tlast_n;
    logic                  busy_n;
    logic                  timeout_err_n;

    logic [DATA_WIDTH-1:0] x, y, x_next, y_next;
    logic                  eol, eof;
    logic                  cnt_clear, cnt_advance;

    logic [RBG_SIZE-1:0]   hit_colour;
    logic                  hit_ok;

    raster_counter #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .x       (x),
        .y       (y),
        .x_next  (x_next),
        .y_next  (y_next),
        .eol     (eol),
        .eof     (eof)
    );

    // Lowest-indexed hitting queue wins; scanning downwards lets it overwrite.
    always_comb begin
        hit_colour = '0;
        for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
            if (bus.hit_i[q]) hit_colour = bus.colour_i[q*RBG_SIZE +: RBG_SIZE];
        end
    end

    // The first WAIT cycle carries the answer to the previous request.
    assign hit_ok = (|bus.hit_i) && (timer != '0);

    // Next-state and next-output logic for the IDLE/WAIT/SEND sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_n       = state;
        timer_n       = timer;
        xcheck_n      = xcheck;
        ycheck_n      = ycheck;
        tdata_n       = tdata;
        tvalid_n      = tvalid;
        tuser_n       = tuser;
        tlast_n       = tlast;
        busy_n        = busy;
        timeout_err_n = timeout_err;
        cnt_clear     = 1'b0;
        cnt_advance   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_clear     = 1'b1;
                    timeout_err_n = 1'b0;
                    busy_n        = 1'b1;
                    timer_n       = '0;
                    xcheck_n      = '0;
                    ycheck_n      = '0;
                    state_n       = WAIT;
                end
            end

            WAIT: begin
                timer_n = timer + 1'b1;
                if (hit_ok || timer == TIMER_LAST) begin
                    tdata_n  = hit_ok ? {TDATA_PAD, hit_colour} : '0;
                    tvalid_n = 1'b1;
                    tuser_n  = (x == '0) && (y == '0);
                    tlast_n  = eol;
                    xcheck_n = COORD_IDLE;
                    ycheck_n = COORD_IDLE;
                    state_n  = SEND;
                    if (!hit_ok) timeout_err_n = 1'b1;
                end
            end

            SEND: begin
                if (tvalid && bus.out_tready) begin
                    tvalid_n    = 1'b0;
                    timer_n     = '0;
                    cnt_advance = 1'b1;
                    if (eof) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        xcheck_n = x_next;
                        ycheck_n = y_next;
                        state_n  = WAIT;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            xcheck      <= COORD_IDLE;
            ycheck      <= COORD_IDLE;
            tdata       <= '0;
            tvalid      <= 1'b0;
            tuser       <= 1'b0;
            tlast       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            xcheck      <= xcheck_n;
            ycheck      <= ycheck_n;
            tdata       <= tdata_n;
            tvalid      <= tvalid_n;
            tuser       <= tuser_n;
            tlast       <= tlast_n;
            busy        <= busy_n;
            timeout_err <= timeout_err_n;
        end
    end

    assign bus.xpixel_check = xcheck;
    assign bus.ypixel_check = ycheck;
    assign bus.out_tdata    = tdata;
    assign bus.out_tvalid   = tvalid;
    assign bus.out_tuser    = tuser;
    assign bus.out_tlast    = tlast;

endmodule

// File: tb/tb_pixel_combinator.sv
// Scoreboard bench for pixel_combinator on a 4x2 screen with two queues.
module tb_pixel_combinator;
    import pixel_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NQ = 2;
    localparam int TO = 16;
    localparam int CW = 24;
    localparam logic [31:0] IDLE_C = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic timeout_err;

    pixel_combinator_if #(.DATA_WIDTH(32), .RBG_SIZE(CW), .NUM_QUEUES(NQ)) bus ();

    pixel_combinator #(
        .DATA_WIDTH(32), .RBG_SIZE(CW), .NUM_QUEUES(NQ),
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Queue contents: which queue holds which pixel, with which colour.
    logic    plan_v [0:NQ-1][0:H-1][0:W-1];
    colour_t plan_c [0:NQ-1][0:H-1][0:W-1];

    logic [NQ-1:0]    inj_hit = '0;
    logic [NQ*CW-1:0] inj_col = '0;
    int               rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main

    typedef struct {
        logic [31:0] tdata;
        logic        tuser;
        logic        tlast;
        int          gap;
    } beat_t;
    beat_t sb [$];
    logic  exp_to;

    // Queue model: registers a coordinate match at the edge, pops the entry,
    // and presents hit/colour during the following cycle.
    always @(posedge clk) begin : responder
        logic [NQ-1:0]    nh;
        logic [NQ*CW-1:0] nc;
        logic [31:0]      cx, cy;
        nh = '0;
        nc = '0;
        cx = bus.xpixel_check;
        cy = bus.ypixel_check;
        if (cx < W && cy < H) begin
            for (int q = 0; q < NQ; q++) begin
                if (plan_v[q][cy][cx]) begin
                    nh[q] = 1'b1;
                    nc[q*CW +: CW] = plan_c[q][cy][cx];
                    plan_v[q][cy][cx] = 1'b0;
                end
            end
        end
        #1;
        bus.hit_i    = nh | inj_hit;
        bus.colour_i = nc | inj_col;
    end

    always @(posedge clk) begin : ready_driver
        #1;
        if (rdy_mode == 0) bus.out_tready = 1'b1;
        else if (rdy_mode == 1) bus.out_tready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each handshake, checks held beats stay
    // stable, the request is parked while a beat is offered, and WAIT length.
    int          gap = 0;
    logic        stalled = 1'b0;
    logic [31:0] held_d;
    logic        held_u, held_l;

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!reset) begin
            stalled = 1'b0;
            gap = 0;
        end else if (bus.out_tvalid) begin
            check("send_xcheck_idle", bus.xpixel_check, IDLE_C);
            check("send_ycheck_idle", bus.ypixel_check, IDLE_C);
            if (stalled) begin
                check("stall_tdata", bus.out_tdata, held_d);
                check("stall_tuser", {31'd0, bus.out_tuser}, {31'd0, held_u});
                check("stall_tlast", {31'd0, bus.out_tlast}, {31'd0, held_l});
            end
            if (bus.out_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h expected=none t=%0t", bus.out_tdata, $time);
                end else begin
                    e = sb.pop_front();
                    check("beat_tdata", bus.out_tdata, e.tdata);
                    check("beat_tuser", {31'd0, bus.out_tuser}, {31'd0, e.tuser});
                    check("beat_tlast", {31'd0, bus.out_tlast}, {31'd0, e.tlast});
                    check("beat_wait_cycles", gap, e.gap);
                end
                gap = 0;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d = bus.out_tdata;
                held_u = bus.out_tuser;
                held_l = bus.out_tlast;
            end
        end else begin
            stalled = 1'b0;
            if (busy) gap++;
        end
    end

    task automatic clear_plan();
        for (int q = 0; q < NQ; q++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    plan_v[q][y][x] = 1'b0;
                    plan_c[q][y][x] = '0;
                end
    endtask

    // Pixel (x,y) held by queue x%2 with colour x+10*y.
    task automatic plan_directed();
        clear_plan();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                plan_v[x % 2][y][x] = 1'b1;
                plan_c[x % 2][y][x] = colour_t'(x + 10 * y);
            end
    endtask

    task automatic plan_random();
        int r;
        int q;
        clear_plan();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                r = $urandom_range(0, 9);
                if (r == 0) continue;
                if (r <= 2) begin
                    for (int k = 0; k < NQ; k++) begin
                        plan_v[k][y][x] = 1'b1;
                        plan_c[k][y][x] = colour_t'($urandom);
                    end
                end else begin
                    q = $urandom_range(0, NQ - 1);
                    plan_v[q][y][x] = 1'b1;
                    plan_c[q][y][x] = colour_t'($urandom);
                end
            end
    endtask

    // Reference: raster order, colour from the lowest queue holding the pixel,
    // black after a full timeout when nobody holds it.
    task automatic build_expected();
        beat_t b;
        logic found;
        exp_to = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                found = 1'b0;
                b.tdata = 32'd0;
                for (int q = 0; q < NQ; q++) begin
                    if (!found && plan_v[q][y][x]) begin
                        found = 1'b1;
                        b.tdata = {8'h00, plan_c[q][y][x]};
                    end
                end
                b.tuser = (x == 0 && y == 0);
                b.tlast = (x == W - 1);
                b.gap   = found ? 2 : TO;
                if (!found) exp_to = 1'b1;
                sb.push_back(b);
            end
    endtask

    // Pulse start; optionally drive a stale hit into the first WAIT cycle.
    task automatic start_frame(input bit stale);
        build_expected();
        @(posedge clk);
        #1;
        start = 1'b1;
        if (stale) begin
            inj_hit = 2'b01;
            inj_col = {24'h0, 24'hDEAD01};
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        inj_hit = '0;
        inj_col = '0;
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_drained"}, sb.size(), 32'd0);
        check({tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, exp_to});
        check({tag, "_idle_x"}, bus.xpixel_check, IDLE_C);
        check({tag, "_idle_y"}, bus.ypixel_check, IDLE_C);
    endtask

    task automatic wait_tvalid(input string tag);
        int n = 0;
        while (!bus.out_tvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tvalid_seen"}, {31'd0, bus.out_tvalid}, 32'd1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.hit_i = '0;
        bus.colour_i = '0;
        bus.out_tready = 1'b1;
        clear_plan();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", {31'd0, bus.out_tvalid}, 32'd0);
        check("rst_tdata", bus.out_tdata, 32'd0);
        check("rst_tuser", {31'd0, bus.out_tuser}, 32'd0);
        check("rst_tlast", {31'd0, bus.out_tlast}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_xcheck", bus.xpixel_check, IDLE_C);
        check("rst_ycheck", bus.ypixel_check, IDLE_C);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed frame, with a stale hit in the first WAIT cycle
        rdy_mode = 0;
        plan_directed();
        start_frame(1'b1);
        finish_frame("directed");

        // Simultaneous hits: lowest queue wins
        plan_directed();
        plan_v[0][0][0] = 1'b1; plan_c[0][0][0] = 24'hAAAAAA;
        plan_v[1][0][0] = 1'b1; plan_c[1][0][0] = 24'h555555;
        start_frame(1'b0);
        finish_frame("dual_hit");

        // Sink stalls for 5 cycles on the first beat
        plan_directed();
        rdy_mode = 2;
        bus.out_tready = 1'b0;
        start_frame(1'b0);
        wait_tvalid("hold");
        repeat (5) begin
            @(negedge clk);
            check("hold_tvalid", {31'd0, bus.out_tvalid}, 32'd1);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        bus.out_tready = 1'b1;
        finish_frame("hold");

        // Pixel (1,0) never answered: black beat after a full timeout
        plan_directed();
        plan_v[1][0][1] = 1'b0;
        start_frame(1'b0);
        finish_frame("timeout");
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        plan_directed();
        start_frame(1'b0);
        check("timeout_err_cleared", {31'd0, timeout_err}, 32'd0);
        finish_frame("after_timeout");

        // Reset while a beat is waiting in SEND
        plan_directed();
        rdy_mode = 2;
        bus.out_tready = 1'b0;
        start_frame(1'b0);
        wait_tvalid("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_tvalid", {31'd0, bus.out_tvalid}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_xcheck", bus.xpixel_check, IDLE_C);
        check("midreset_ycheck", bus.ypixel_check, IDLE_C);
        reset = 1'b1;
        sb.delete();
        clear_plan();
        gap = 0;
        rdy_mode = 0;
        bus.out_tready = 1'b1;
        plan_directed();
        start_frame(1'b0);
        finish_frame("after_reset");

        // Hits while idle change nothing
        inj_hit = 2'b11;
        inj_col = {24'h123456, 24'h654321};
        repeat (6) begin
            @(negedge clk);
            check("idle_hit_tvalid", {31'd0, bus.out_tvalid}, 32'd0);
            check("idle_hit_busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk);
        #2;
        inj_hit = '0;
        inj_col = '0;
        @(posedge clk);

        // Random frames; the first gets a start pulse while busy
        for (int f = 0; f < 8; f++) begin
            rdy_mode = 1;
            plan_random();
            start_frame(f[0]);
            if (f == 0) begin
                repeat (10) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            finish_frame("random");
        end

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
